// File: rtl/tile_video_pkg.sv
// Shared constants and types for the tile video scan-out path.
// Holds the 640x480@60 timing, playfield geometry, the palette and the
// tile pattern definition used by the pattern ROM.
package tile_video_pkg;

  // 640x480@60 timing
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  // Playfield geometry
  localparam int unsigned TILE_W = 16;
  localparam int unsigned TILE_H = 16;
  localparam int unsigned COLS   = 40;
  localparam int unsigned ROWS   = 30;

  // Datapath widths
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned ROW_W  = 16;

  localparam logic [RGB_W-1:0] BG_RGB = 12'h000;

  localparam logic [RGB_W-1:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  // Sync/visibility flags that travel down the delay pipe with each pixel
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
    logic frame_start;
  } scan_tag_t;

  localparam scan_tag_t TAG_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, frame_start: 1'b0};

  // Row bits of a tile shape; MSB is the leftmost pixel.
  // Shape 0 is blank, shape 15 is solid, the rest repeat (shape ^ row) as a 4-px motif.
  function automatic logic [ROW_W-1:0] pattern_row(input logic [3:0] shape, input logic [3:0] row);
    logic [ROW_W-1:0] bits;
    bits = {4{shape ^ row}};
    if (shape == 4'h0) begin
      bits = '0;
    end else if (shape == 4'hF) begin
      bits = '1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/tile_pattern_rom.sv
// 256x16 tile pattern ROM with one registered read port.
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset, clears the read register
//   i_addr     {shape[3:0], row[3:0]}
//   o_row_bits 16 pixel bits of that row, MSB leftmost, valid the cycle after i_addr
module tile_pattern_rom
  import tile_video_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_addr,
  output logic [ROW_W-1:0] o_row_bits
);

  logic [ROW_W-1:0] r_row_bits;

  // Contents are a fixed function of the address, so the read is a constant table
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_bits <= '0;
    end else begin
      r_row_bits <= pattern_row(i_addr[7:4], i_addr[3:0]);
    end
  end

  assign o_row_bits = r_row_bits;

endmodule

// File: rtl/tile_scan_renderer.sv
// Tile-map scan-out: VGA timing, tile RAM addressing and pixel expansion.
// Ports:
//   clk          pixel clock, also the tile RAM read clock
//   rst          synchronous active-high reset
//   vram_addr    tile RAM read address (combinational from the scan counters)
//   vram_data    tile byte returned one cycle after vram_addr: [7:4] shape, [3:0] palette
//   hsync/vsync  active-low syncs, aligned with de/rgb
//   de           display enable
//   rgb          {R,G,B} 4 bits each, zero outside the visible area
//   frame_start  one-cycle pulse at output time of (h=0, v=V_ACTIVE)
// Timing parameters default to 640x480@60; they exist so the same scan
// logic can run reduced rasters.
module tile_scan_renderer
  import tile_video_pkg::*;
#(
  parameter int unsigned H_ACT    = H_ACTIVE,
  parameter int unsigned H_FPORCH = H_FP,
  parameter int unsigned H_SYNCW  = H_SYNC,
  parameter int unsigned H_BPORCH = H_BP,
  parameter int unsigned V_ACT    = V_ACTIVE,
  parameter int unsigned V_FPORCH = V_FP,
  parameter int unsigned V_SYNCW  = V_SYNC,
  parameter int unsigned V_BPORCH = V_BP
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [DATA_W-1:0] vram_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [RGB_W-1:0]  rgb,
  output logic              frame_start
);

  localparam int unsigned H_TOT = H_ACT + H_FPORCH + H_SYNCW + H_BPORCH;
  localparam int unsigned V_TOT = V_ACT + V_FPORCH + V_SYNCW + V_BPORCH;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACT + H_FPORCH);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACT + H_FPORCH + H_SYNCW - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACT + V_FPORCH);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACT + V_FPORCH + V_SYNCW - 1);

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_h_last;
  logic             w_v_last;
  scan_tag_t        w_tag;

  scan_tag_t        r_s1_tag;
  logic [3:0]       r_s1_hpix;
  logic [3:0]       r_s1_vrow;

  scan_tag_t        r_s2_tag;
  logic [3:0]       r_s2_hpix;
  logic [3:0]       r_s2_pal;
  logic [ROW_W-1:0] w_row_bits;
  logic             w_lit;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [RGB_W-1:0] r_rgb;
  logic             r_frame_start;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);

  // Scan position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
    end else begin
      r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  // Stage-0 decode of syncs, visibility and frame start
  always_comb begin
    w_tag             = TAG_IDLE;
    w_tag.visible     = (r_hcnt < H_VIS_END) && (r_vcnt < V_VIS_END);
    w_tag.hsync       = !((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST));
    w_tag.vsync       = !((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST));
    w_tag.frame_start = (r_hcnt == '0) && (r_vcnt == V_VIS_END);
  end

  // Tile address is row*64+col; parked at 0 in blanking so it is never X
  assign vram_addr = w_tag.visible ? {r_vcnt[8:4], r_hcnt[9:4]} : '0;

  // Stage 1: tags travel alongside the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_tag  <= TAG_IDLE;
      r_s1_hpix <= '0;
      r_s1_vrow <= '0;
    end else begin
      r_s1_tag  <= w_tag;
      r_s1_hpix <= r_hcnt[3:0];
      r_s1_vrow <= r_vcnt[3:0];
    end
  end

  tile_pattern_rom u_rom (
    .clk        (clk),
    .rst        (rst),
    .i_addr     ({vram_data[7:4], r_s1_vrow}),
    .o_row_bits (w_row_bits)
  );

  // Stage 2: palette index and pixel column line up with the ROM output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_tag  <= TAG_IDLE;
      r_s2_hpix <= '0;
      r_s2_pal  <= '0;
    end else begin
      r_s2_tag  <= r_s1_tag;
      r_s2_hpix <= r_s1_hpix;
      r_s2_pal  <= vram_data[3:0];
    end
  end

  // ~hpix selects bit 15-hpix, so pixel 0 of the tile takes the MSB
  assign w_lit = w_row_bits[~r_s2_hpix] && (r_s2_pal != 4'h0);

  // Stage 3: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= r_s2_tag.hsync;
      r_vsync       <= r_s2_tag.vsync;
      r_de          <= r_s2_tag.visible;
      r_frame_start <= r_s2_tag.frame_start;
      if (!r_s2_tag.visible) begin
        r_rgb <= '0;
      end else if (w_lit) begin
        r_rgb <= PALETTE[r_s2_pal];
      end else begin
        r_rgb <= BG_RGB;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_tile_scan_renderer.sv
// Bench for tile_scan_renderer: a full-timing instance (A) and a reduced-raster
// instance (B, 80x55 total) so whole frames fit in a short run. Each output is
// compared every cycle against a raster model computed from scan position.
module tb_tile_scan_renderer;
  import tile_video_pkg::*;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
  } tim_t;

  localparam tim_t TIM_A = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t TIM_B = '{64, 4, 8, 4, 48, 2, 2, 3};

  logic        clk;
  logic        rst_a, rst_b;
  logic [10:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic        hs_a, vs_a, de_a, fs_a;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [11:0] rgb_a, rgb_b;

  logic [7:0]  mem_a [2048];
  logic [7:0]  mem_b [2048];

  int n_chk = 0;
  int n_err = 0;
  int k_a = 0;
  int k_b = 0;
  bit released = 0;
  bit b_done = 0;
  bit tally_a_en = 1;
  int t0_hits = 0;
  int t23_lit = 0;

  tile_scan_renderer u_dut_a (
    .clk(clk), .rst(rst_a), .vram_addr(addr_a), .vram_data(data_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  tile_scan_renderer #(
    .H_ACT(64), .H_FPORCH(4), .H_SYNCW(8), .H_BPORCH(4),
    .V_ACT(48), .V_FPORCH(2), .V_SYNCW(2), .V_BPORCH(3)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .vram_addr(addr_b), .vram_data(data_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile RAMs with a one-cycle registered read
  always @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int sel, input int a);
    return (sel == 0) ? mem_a[a] : mem_b[a];
  endfunction

  // Is pixel (h,v) lit by its tile byte b?
  function automatic bit ref_lit(input logic [7:0] b, input int h, input int v);
    int shape, pal, x, r;
    shape = int'(b[7:4]);
    pal   = int'(b[3:0]);
    x     = h % 16;
    r     = v % 16;
    if (pal == 0)   return 1'b0;
    if (shape == 0) return 1'b0;
    if (shape == 15) return 1'b1;
    return (((shape ^ r) >> (3 - (x % 4))) & 1) != 0;
  endfunction

  // k = clock edges since reset; counters sit at position k, outputs show position k-3
  task automatic check_all(input string nm, input tim_t t, input int sel, input int k,
                           input logic [10:0] addr, input logic hs, input logic vs,
                           input logic de_i, input logic [11:0] px, input logic fs);
    int ht, vt, h, v, q;
    logic [7:0] b;
    logic eh, ev, ede, efs;
    logic [11:0] epx;
    logic [10:0] eaddr;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    h = k % ht;
    v = (k / ht) % vt;
    eaddr = (h < t.ha && v < t.va) ? 11'((v / 16) * 64 + h / 16) : 11'd0;
    check({nm, ".addr"}, 32'(addr), 32'(eaddr));
    if (k < 3) begin
      eh = 1'b1; ev = 1'b1; ede = 1'b0; epx = 12'h000; efs = 1'b0;
    end else begin
      q   = k - 3;
      h   = q % ht;
      v   = (q / ht) % vt;
      eh  = !(h >= t.ha + t.hf && h < t.ha + t.hf + t.hs);
      ev  = !(v >= t.va + t.vf && v < t.va + t.vf + t.vs);
      ede = (h < t.ha) && (v < t.va);
      efs = (h == 0) && (v == t.va);
      epx = 12'h000;
      if (ede) begin
        b = mem_byte(sel, (v / 16) * 64 + h / 16);
        epx = ref_lit(b, h, v) ? PALETTE[b[3:0]] : BG_RGB;
      end
    end
    check({nm, ".hsync"}, 32'(hs), 32'(eh));
    check({nm, ".vsync"}, 32'(vs), 32'(ev));
    check({nm, ".de"}, 32'(de_i), 32'(ede));
    check({nm, ".rgb"}, 32'(px), 32'(epx));
    check({nm, ".fs"}, 32'(fs), 32'(efs));
  endtask

  // Per-cycle checker, instance A, plus tallies for the first-row tiles
  initial begin : chk_a
    logic r;
    int q, h, v;
    forever begin
      @(posedge clk);
      r = rst_a;
      #1;
      if (r) k_a = 0; else k_a++;
      check_all("A", TIM_A, 0, k_a, addr_a, hs_a, vs_a, de_a, rgb_a, fs_a);
      if (!r && k_a >= 3 && tally_a_en) begin
        q = k_a - 3;
        h = q % 800;
        v = (q / 800) % 525;
        if (h < 16 && v < 16 && rgb_a == PALETTE[5]) t0_hits++;
        if (v < 16 && h >= 32 && h < 64 && rgb_a != 12'h000) t23_lit++;
      end
    end
  end

  // Per-cycle checker, instance B
  initial begin : chk_b
    logic r;
    forever begin
      @(posedge clk);
      r = rst_b;
      #1;
      if (r) k_b = 0; else k_b++;
      check_all("B", TIM_B, 1, k_b, addr_b, hs_b, vs_b, de_b, rgb_b, fs_b);
    end
  end

  task automatic wait_k_a(input int n);
    while (k_a < n) @(negedge clk);
  endtask

  // Whole-frame tallies on the reduced raster: corner tile only, syncs, frame pulse
  initial begin : frame_b
    int lit, p3, vlow, fsn, amax;
    wait (released);
    while (k_b < 3) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      lit = 0; p3 = 0; vlow = 0; fsn = 0; amax = 0;
      repeat (4400) begin
        if (rgb_b != 12'h000) lit++;
        if (rgb_b == PALETTE[3]) p3++;
        if (vs_b == 1'b0) vlow++;
        if (fs_b == 1'b1) fsn++;
        if (int'(addr_b) > amax) amax = int'(addr_b);
        @(negedge clk);
      end
      check("B.frame_lit", 32'(lit), 32'd256);
      check("B.frame_pal3", 32'(p3), 32'd256);
      check("B.frame_vsync_low", 32'(vlow), 32'd160);
      check("B.frame_start_cnt", 32'(fsn), 32'd1);
      check("B.max_addr", 32'(amax), 32'd131);
    end
    b_done = 1'b1;
  end

  initial begin : main
    int cnt;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'h00;
    end
    mem_a[0] = 8'hF5;
    mem_a[1] = 8'h00;
    mem_a[2] = 8'h07;
    mem_a[3] = 8'hF0;
    mem_b[131]  = 8'hF3;
    mem_b[1895] = 8'hF3;

    repeat (5) @(negedge clk);
    check("rst_hsync", 32'(hs_a), 32'd1);
    check("rst_vsync", 32'(vs_a), 32'd1);
    check("rst_de", 32'(de_a), 32'd0);
    check("rst_rgb", 32'(rgb_a), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    released = 1'b1;

    // First visible pixel appears on the third edge after release
    cnt = 0;
    while (cnt < 10 && de_a !== 1'b1) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("first_de_cycles", 32'(cnt), 32'd3);

    // One full line of hsync
    wait_k_a(803);
    cnt = 0;
    repeat (800) begin
      @(negedge clk);
      if (hs_a == 1'b0) cnt++;
    end
    check("A.line_hsync_low", 32'(cnt), 32'd96);

    // Tile row 0 done; swap RAM contents during horizontal blanking
    wait_k_a(40 * 800 + 700);
    tally_a_en = 1'b0;
    check("A.tile0_pal5_px", 32'(t0_hits), 32'd256);
    check("A.tile23_lit_px", 32'(t23_lit), 32'd0);
    for (int i = 0; i < 2048; i++) mem_a[i] = 8'hFF;

    // Mid-frame reset while solid tiles are on screen
    wait_k_a(44 * 800 + 300);
    check("A.pre_rst_rgb", 32'(rgb_a), 32'(PALETTE[15]));
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("A.midrst_rgb", 32'(rgb_a), 32'd0);
    check("A.midrst_de", 32'(de_a), 32'd0);
    check("A.midrst_addr", 32'(addr_a), 32'd0);
    wait_k_a(3);
    check("A.resume_rgb", 32'(rgb_a), 32'(PALETTE[15]));
    wait_k_a(20 * 800);

    wait (b_done);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
